cruise_speed_fsm: RTL and testbench
===================================

// Module: cruise_speed_fsm
// PURPOSE
//  Cruise-control supervisor sitting directly upstream of the 3-bit speed counter.
//  Reads the counter's speed value and driver inputs; drives the counter's
//  enable/mode/preset/load controls to accelerate, decelerate or hold a latched target.
//  Applies speed steps at a fixed prescaled rate and never requests counter wrap-around.
// PARAMETERS
//  SPEED_W    3   width of speed/target/load buses
//  STEP_DIV   4   clk cycles per speed step (>=2); ctr_enable pulses once per period
//  MIN_SPEED  2   lowest speed at which cruise may be engaged or resumed
// PORTS
//  clk          in   1        system clock, rising edge
//  clear        in   1        synchronous active-high reset
//  power        in   1        cruise system on; 0 forces OFF within one cycle
//  set_btn      in   1        level; rising edge engages/re-targets cruise
//  resume_btn   in   1        level; rising edge resumes stored target (see CONFIGURATION)
//  cancel_btn   in   1        level; leave cruise, same priority as brake
//  brake        in   1        brake pedal; highest priority after power/clear
//  accel_pedal  in   1        driver acceleration request
//  speed        in   SPEED_W  current counter output
//  ctr_enable   out  1        one-cycle step pulse to counter
//  ctr_mode     out  1        1 = count up, 0 = count down; valid with ctr_enable
//  ctr_preset   out  1        one-cycle load strobe to counter
//  ctr_load     out  SPEED_W  value loaded on ctr_preset
//  target_speed out  SPEED_W  latched cruise target
//  cruise_on    out  1        high in CRUISE and ACCEL states
//  state_o      out  3        current state encoding (debug)
// BEHAVIOUR
//  Reset (clear=1, sync): state OFF; all outputs 0; target 0; prescaler 0; edge regs 0.
//  All outputs registered. Prescaler counts 0..STEP_DIV-1, free-running outside OFF;
//   step slot = cycle where prescaler==STEP_DIV-1; ctr_enable only asserted in a slot.
//  States: OFF, IDLE, CRUISE, ACCEL.
//   OFF: power=1 -> IDLE; on that transition ctr_preset=1, ctr_load=0 for one cycle.
//   IDLE: manual. accel_pedal -> step up; brake -> step down; both -> down.
//    set_btn rise & speed>=MIN_SPEED -> CRUISE, target<=speed. Below MIN_SPEED: ignored.
//   CRUISE: speed<target step up; speed>target step down; equal -> no pulse.
//    accel_pedal -> ACCEL. brake|cancel_btn -> IDLE. set_btn rise -> target<=speed.
//   ACCEL: step up each slot; accel_pedal falls -> CRUISE with target<=speed.
//    brake|cancel_btn -> IDLE.
//  Priority (high->low): clear, power=0 (-> OFF, outputs 0), brake/cancel, set/resume,
//   accel_pedal. Same-cycle set_btn and brake: brake wins, set edge discarded.
//  Saturation: no up-step when speed==all ones; no down-step when speed==0.
//  Latency: input change -> state change 1 cycle; step request -> ctr_enable at next slot.
//  Counter result must be visible within STEP_DIV-1 cycles (STEP_DIV>=2 -> no overshoot).
//  Reset mid-step: any pending ctr_enable/ctr_preset dropped the same edge.
// CONFIGURATION
//  CRUISE_RESUME_EN defined: target and target_valid retained on CRUISE/ACCEL -> IDLE;
//   resume_btn rise in IDLE with target_valid & speed>=MIN_SPEED -> CRUISE (old target).
//   target_valid cleared in OFF and on clear.
//  Not defined: target cleared to 0 on leaving CRUISE/ACCEL; resume_btn ignored.
// STRUCTURE
//  Shared include cruise_defs.vh: state encodings (OFF=0, IDLE=1, CRUISE=2, ACCEL=3),
//   CTR_UP=1 / CTR_DOWN=0 constants, default SPEED_W.
//  One sub-module: cruise_step_timer (prescaler, outputs step slot pulse, sync clear).
//  Edge detection and FSM stay in this module.
// TESTING
//  1 clear=1 3 cycles, power=0 -> all outputs 0, state_o=OFF.
//  2 power 0->1 -> next cycle ctr_preset=1, ctr_load=0, state IDLE; preset lasts 1 cycle.
//  3 IDLE, speed=5, set_btn pulse -> CRUISE, target=5; speed forced 3 -> ctr_mode=1 pulses
//    every 4 cycles until speed=5, then ctr_enable stays 0.
//  4 CRUISE target=5, brake=1 with set_btn rise same cycle -> IDLE, target unchanged;
//    with RESUME_EN resume_btn rise -> CRUISE target=5; without -> target=0, stays IDLE.
//  5 IDLE speed=7, accel_pedal=1 -> no ctr_enable; speed=0, brake=1 -> no ctr_enable.
//  6 ACCEL from target=4, speed climbs to 6, pedal released -> CRUISE target=6;
//    power=0 mid-step -> OFF next cycle, ctr_enable=0.

Source files
------------

// File: rtl/cruise_speed_fsm_pkg.sv
// Shared definitions for the cruise-control supervisor: state encodings,
// counter direction constants and the default speed bus width.
package cruise_speed_fsm_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_CRUISE = 3'd2,
    ST_ACCEL  = 3'd3
  } state_e;

  localparam logic CTR_UP      = 1'b1;
  localparam logic CTR_DOWN    = 1'b0;
  localparam int   DEF_SPEED_W = 3;

  function automatic logic is_engaged(input state_e s);
    return (s == ST_CRUISE) || (s == ST_ACCEL);
  endfunction

endpackage

// File: rtl/cruise_speed_fsm_step_timer.sv
// Free-running prescaler that marks one step slot every STEP_DIV clocks;
// held at zero while clr_i is high.
module cruise_step_timer #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic clr_i,
  output logic slot_o
);

  localparam int              CW   = $clog2(STEP_DIV);
  localparam logic [CW-1:0]   LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign slot_o = (cnt_q == LAST);

endmodule

// File: rtl/cruise_speed_fsm.sv
// Cruise-control supervisor driving a speed counter's enable/mode/preset controls.
// Define CRUISE_RESUME_EN to keep the target on disengage and allow resume_btn.
module cruise_speed_fsm
  import cruise_speed_fsm_pkg::*;
#(
  parameter int SPEED_W   = DEF_SPEED_W,
  parameter int STEP_DIV  = 4,
  parameter int MIN_SPEED = 2
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               power,
  input  logic               set_btn,
  input  logic               resume_btn,
  input  logic               cancel_btn,
  input  logic               brake,
  input  logic               accel_pedal,
  input  logic [SPEED_W-1:0] speed,
  output logic               ctr_enable,
  output logic               ctr_mode,
  output logic               ctr_preset,
  output logic [SPEED_W-1:0] ctr_load,
  output logic [SPEED_W-1:0] target_speed,
  output logic               cruise_on,
  output logic [2:0]         state_o
);

`ifdef CRUISE_RESUME_EN
  localparam bit RESUME_EN = 1'b1;
`else
  localparam bit RESUME_EN = 1'b0;
`endif

  localparam logic [SPEED_W-1:0] SPD_MAX = '1;
  localparam logic [SPEED_W-1:0] SPD_MIN = SPEED_W'(MIN_SPEED);

  state_e               state_q, state_d;
  logic [SPEED_W-1:0]   target_q, target_d;
  logic                 tv_q, tv_d;
  logic                 set_q, res_q;
  logic                 en_q, en_d, mode_q, mode_d, preset_q, preset_d, on_q, on_d;
  logic                 slot, timer_clr;
  logic                 set_rise, res_rise, stop, up_req, dn_req, up_ok, dn_ok;

  assign timer_clr = clear | (state_q == ST_OFF);

  cruise_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clk   (clk),
    .clr_i (timer_clr),
    .slot_o(slot)
  );

  always_comb begin
    set_rise = set_btn & ~set_q;
    res_rise = resume_btn & ~res_q;
    stop     = brake | cancel_btn;
    state_d  = state_q;
    target_d = target_q;
    tv_d     = tv_q;
    up_req   = 1'b0;
    dn_req   = 1'b0;
    preset_d = 1'b0;
    case (state_q)
      ST_OFF: begin
        target_d = '0;
        tv_d     = 1'b0;
        if (power) begin
          state_d  = ST_IDLE;
          preset_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (brake)            dn_req = 1'b1;
        else if (accel_pedal) up_req = 1'b1;
        // A stop request swallows any same-cycle set/resume edge.
        if (!stop && speed >= SPD_MIN) begin
          if (set_rise) begin
            state_d  = ST_CRUISE;
            target_d = speed;
            tv_d     = 1'b1;
          end else if (RESUME_EN && res_rise && tv_q) begin
            state_d = ST_CRUISE;
          end
        end
      end
      ST_CRUISE, ST_ACCEL: begin
        if (stop) begin
          state_d = ST_IDLE;
          if (!RESUME_EN) begin
            target_d = '0;
            tv_d     = 1'b0;
          end
        end else if (state_q == ST_ACCEL) begin
          if (accel_pedal) begin
            up_req = 1'b1;
          end else begin
            state_d  = ST_CRUISE;
            target_d = speed;
          end
        end else begin
          if (set_rise)            target_d = speed;
          if (accel_pedal) begin
            state_d = ST_ACCEL;
            up_req  = 1'b1;
          end else if (speed < target_q) begin
            up_req = 1'b1;
          end else if (speed > target_q) begin
            dn_req = 1'b1;
          end
        end
      end
      default: state_d = ST_OFF;
    endcase
    if (!power) begin
      state_d  = ST_OFF;
      target_d = '0;
      tv_d     = 1'b0;
      up_req   = 1'b0;
      dn_req   = 1'b0;
      preset_d = 1'b0;
    end
    up_ok  = up_req & (speed != SPD_MAX);
    dn_ok  = dn_req & (speed != '0);
    en_d   = slot & (up_ok | dn_ok);
    mode_d = (slot & up_ok) ? CTR_UP : CTR_DOWN;
    on_d   = is_engaged(state_d);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= ST_OFF;
      target_q <= '0;
      tv_q     <= 1'b0;
      set_q    <= 1'b0;
      res_q    <= 1'b0;
      en_q     <= 1'b0;
      mode_q   <= 1'b0;
      preset_q <= 1'b0;
      on_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      tv_q     <= tv_d;
      set_q    <= set_btn;
      res_q    <= resume_btn;
      en_q     <= en_d;
      mode_q   <= mode_d;
      preset_q <= preset_d;
      on_q     <= on_d;
    end
  end

  // The preset always loads zero, so the load bus is a constant register image.
  assign ctr_load     = '0;
  assign ctr_enable   = en_q;
  assign ctr_mode     = mode_q;
  assign ctr_preset   = preset_q;
  assign target_speed = target_q;
  assign cruise_on    = on_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cruise_speed_fsm.sv
// Directed bench for cruise_speed_fsm with a behavioural model of the speed counter.
module tb_cruise_speed_fsm;

`ifdef CRUISE_RESUME_EN
  localparam bit RES = 1'b1;
`else
  localparam bit RES = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear, power, set_btn, resume_btn, cancel_btn, brake, accel_pedal;
  logic [2:0] speed;
  logic       ctr_enable, ctr_mode, ctr_preset, cruise_on;
  logic [2:0] ctr_load, target_speed, state_o;

  int n_checks = 0;
  int n_fail   = 0;

  cruise_speed_fsm #(.SPEED_W(3), .STEP_DIV(4), .MIN_SPEED(2)) dut (
    .clk(clk), .clear(clear), .power(power), .set_btn(set_btn),
    .resume_btn(resume_btn), .cancel_btn(cancel_btn), .brake(brake),
    .accel_pedal(accel_pedal), .speed(speed), .ctr_enable(ctr_enable),
    .ctr_mode(ctr_mode), .ctr_preset(ctr_preset), .ctr_load(ctr_load),
    .target_speed(target_speed), .cruise_on(cruise_on), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, applying every observed step pulse to the modelled speed.
  task automatic step_model(input int n, output int ups, output int dns);
    ups = 0;
    dns = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ctr_enable) begin
        if (ctr_mode) begin ups++; speed = speed + 3'd1; end
        else          begin dns++; speed = speed - 3'd1; end
      end
    end
  endtask

  task automatic test_reset;
    clear = 1'b1; power = 1'b0; set_btn = 1'b0; resume_btn = 1'b0;
    cancel_btn = 1'b0; brake = 1'b0; accel_pedal = 1'b0; speed = 3'd0;
    repeat (3) tick();
    n_checks++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    n_checks++;
    if ({ctr_enable, ctr_mode, ctr_preset, ctr_load, target_speed, cruise_on} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {ctr_enable, ctr_mode, ctr_preset, ctr_load, target_speed, cruise_on});
    end
  endtask

  task automatic test_power_on;
    clear = 1'b0;
    tick();
    n_checks++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL off_hold: got %0d expected 0", state_o); end
    power = 1'b1;
    tick();
    n_checks++;
    if (state_o !== 3'd1) begin n_fail++; $display("FAIL power_idle: got %0d expected 1", state_o); end
    n_checks++;
    if (ctr_preset !== 1'b1 || ctr_load !== 3'd0) begin
      n_fail++; $display("FAIL power_preset: got %b/%0d expected 1/0", ctr_preset, ctr_load);
    end
    tick();
    n_checks++;
    if (ctr_preset !== 1'b0) begin n_fail++; $display("FAIL preset_width: got %b expected 0", ctr_preset); end
  endtask

  task automatic test_cruise_hold;
    int u, d, pulses, last;
    bit gap_ok, mode_bad;
    speed = 3'd5; set_btn = 1'b1;
    tick();
    set_btn = 1'b0;
    n_checks++;
    if (state_o !== 3'd2 || target_speed !== 3'd5 || cruise_on !== 1'b1) begin
      n_fail++; $display("FAIL engage: got st=%0d tgt=%0d on=%b expected 2/5/1", state_o, target_speed, cruise_on);
    end
    step_model(8, u, d);
    n_checks++;
    if (u + d !== 0) begin n_fail++; $display("FAIL hold_no_step: got %0d pulses expected 0", u + d); end
    speed = 3'd3; pulses = 0; last = -1; gap_ok = 1'b1; mode_bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ctr_enable) begin
        if (!ctr_mode) mode_bad = 1'b1;
        if (last >= 0 && i - last != 4) gap_ok = 1'b0;
        last = i;
        pulses++;
        speed = ctr_mode ? speed + 3'd1 : speed - 3'd1;
      end
    end
    n_checks++;
    if (pulses !== 2) begin n_fail++; $display("FAIL catchup_pulses: got %0d expected 2", pulses); end
    n_checks++;
    if (!gap_ok) begin n_fail++; $display("FAIL catchup_period: got gap!=4 expected 4"); end
    n_checks++;
    if (mode_bad) begin n_fail++; $display("FAIL catchup_mode: got down expected up"); end
    n_checks++;
    if (speed !== 3'd5) begin n_fail++; $display("FAIL catchup_speed: got %0d expected 5", speed); end
  endtask

  task automatic test_brake_set;
    logic [2:0] keep;
    keep = RES ? 3'd5 : 3'd0;
    brake = 1'b1; set_btn = 1'b1;
    tick();
    brake = 1'b0;
    n_checks++;
    if (state_o !== 3'd1 || cruise_on !== 1'b0) begin
      n_fail++; $display("FAIL brake_exit: got st=%0d on=%b expected 1/0", state_o, cruise_on);
    end
    n_checks++;
    if (target_speed !== keep) begin n_fail++; $display("FAIL brake_target: got %0d expected %0d", target_speed, keep); end
    tick();
    set_btn = 1'b0;
    n_checks++;
    if (state_o !== 3'd1) begin n_fail++; $display("FAIL set_discarded: got %0d expected 1", state_o); end
    tick();
    resume_btn = 1'b1;
    tick();
    resume_btn = 1'b0;
    n_checks++;
    if (state_o !== (RES ? 3'd2 : 3'd1) || target_speed !== keep) begin
      n_fail++; $display("FAIL resume: got st=%0d tgt=%0d expected %0d/%0d", state_o, target_speed, RES ? 2 : 1, keep);
    end
    cancel_btn = 1'b1;
    tick();
    cancel_btn = 1'b0;
    tick();
    n_checks++;
    if (state_o !== 3'd1) begin n_fail++; $display("FAIL cancel: got %0d expected 1", state_o); end
  endtask

  task automatic test_idle_manual;
    int u, d;
    speed = 3'd3; accel_pedal = 1'b1;
    step_model(8, u, d);
    n_checks++;
    if (u !== 2 || d !== 0) begin n_fail++; $display("FAIL manual_up: got up=%0d dn=%0d expected 2/0", u, d); end
    accel_pedal = 1'b0; brake = 1'b1;
    step_model(8, u, d);
    n_checks++;
    if (u !== 0 || d !== 2) begin n_fail++; $display("FAIL manual_down: got up=%0d dn=%0d expected 0/2", u, d); end
    accel_pedal = 1'b1;
    step_model(8, u, d);
    n_checks++;
    if (u !== 0 || d !== 2 || speed !== 3'd1) begin
      n_fail++; $display("FAIL both_pedals: got up=%0d dn=%0d spd=%0d expected 0/2/1", u, d, speed);
    end
    brake = 1'b0; speed = 3'd7;
    step_model(8, u, d);
    n_checks++;
    if (u + d !== 0) begin n_fail++; $display("FAIL sat_top: got %0d pulses expected 0", u + d); end
    accel_pedal = 1'b0; brake = 1'b1; speed = 3'd0;
    step_model(8, u, d);
    n_checks++;
    if (u + d !== 0) begin n_fail++; $display("FAIL sat_bottom: got %0d pulses expected 0", u + d); end
    brake = 1'b0; speed = 3'd1; set_btn = 1'b1;
    tick();
    set_btn = 1'b0;
    tick();
    n_checks++;
    if (state_o !== 3'd1 || target_speed !== (RES ? 3'd5 : 3'd0)) begin
      n_fail++; $display("FAIL set_below_min: got st=%0d tgt=%0d expected 1/%0d", state_o, target_speed, RES ? 5 : 0);
    end
  endtask

  task automatic test_accel_power_off;
    bit got;
    speed = 3'd4; set_btn = 1'b1;
    tick();
    set_btn = 1'b0;
    n_checks++;
    if (state_o !== 3'd2 || target_speed !== 3'd4) begin
      n_fail++; $display("FAIL engage4: got st=%0d tgt=%0d expected 2/4", state_o, target_speed);
    end
    accel_pedal = 1'b1;
    for (int k = 0; k < 20 && speed != 3'd6; k++) begin
      tick();
      if (ctr_enable) speed = ctr_mode ? speed + 3'd1 : speed - 3'd1;
    end
    n_checks++;
    if (state_o !== 3'd3 || speed !== 3'd6 || cruise_on !== 1'b1) begin
      n_fail++; $display("FAIL accel_climb: got st=%0d spd=%0d on=%b expected 3/6/1", state_o, speed, cruise_on);
    end
    accel_pedal = 1'b0;
    tick();
    n_checks++;
    if (state_o !== 3'd2 || target_speed !== 3'd6) begin
      n_fail++; $display("FAIL accel_release: got st=%0d tgt=%0d expected 2/6", state_o, target_speed);
    end
    speed = 3'd3; got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      if (ctr_enable) begin got = 1'b1; speed = speed + 3'd1; end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL cruise_step_timeout: got no pulse expected pulse"); end
    repeat (3) tick();
    power = 1'b0;
    tick();
    n_checks++;
    if (ctr_enable !== 1'b0 || state_o !== 3'd0) begin
      n_fail++; $display("FAIL power_drop: got en=%b st=%0d expected 0/0", ctr_enable, state_o);
    end
    n_checks++;
    if (target_speed !== 3'd0 || cruise_on !== 1'b0) begin
      n_fail++; $display("FAIL power_drop_outs: got tgt=%0d on=%b expected 0/0", target_speed, cruise_on);
    end
  endtask

  task automatic test_clear_mid_step;
    bit got;
    power = 1'b1;
    tick();
    speed = 3'd2; accel_pedal = 1'b1; got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      if (ctr_enable) got = 1'b1;
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL idle_step_timeout: got no pulse expected pulse"); end
    repeat (3) tick();
    clear = 1'b1;
    tick();
    n_checks++;
    if (ctr_enable !== 1'b0 || ctr_preset !== 1'b0 || state_o !== 3'd0) begin
      n_fail++; $display("FAIL clear_mid_step: got en=%b pre=%b st=%0d expected 0/0/0", ctr_enable, ctr_preset, state_o);
    end
    clear = 1'b0; accel_pedal = 1'b0; power = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_cruise_hold();
    test_brake_set();
    test_idle_manual();
    test_accel_power_off();
    test_clear_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
